// File: rtl/comparator_ncen_seq.sv
// comparator_ncen_seq
//   Sequential argmin unit for the centroid-distance path. It takes NUM_CEN
//   unsigned distances, one per accepted beat, and keeps a running best value
//   and its index. After the final beat of a frame it presents the minimum
//   distance and its centroid index as one held result beat. The index of a
//   distance is its position within the frame.
//
//   Optional feature: define CMP_SECOND_BEST_EN to add out_dist2, the
//   second-smallest distance of the frame (winner-confidence margin).
//
// Parameters
//   DATA_W   width of each unsigned distance
//   NUM_CEN  distances per frame (2..1024)
//   IDX_W    width of the winner index / beat counter
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   distance beat valid
//   in_ready   unit can accept a beat (high while accumulating)
//   in_dist    unsigned distance
//   out_valid  result held valid
//   out_ready  consumer accepts result
//   out_dist   minimum distance of the frame
//   out_arg    index of the minimum (lowest index wins ties)
//   out_dist2  second-smallest distance (CMP_SECOND_BEST_EN only)
//   frame_busy at least one beat of the current frame accepted, result not
//              yet handed off
module comparator_ncen_seq #(
  parameter int DATA_W  = 16,
  parameter int NUM_CEN = 8,
  parameter int IDX_W   = $clog2(NUM_CEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dist,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_dist,
  output logic [IDX_W-1:0]  out_arg,
`ifdef CMP_SECOND_BEST_EN
  output logic [DATA_W-1:0] out_dist2,
`endif
  output logic              frame_busy
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  // Counter wraps at NUM_CEN-1 even when NUM_CEN is not a power of two.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CEN - 1);

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    count;
  logic [DATA_W-1:0]   best_dist;
  logic [IDX_W-1:0]    best_arg;
  logic [DATA_W-1:0]   best_dist_nxt;
  logic [IDX_W-1:0]    best_arg_nxt;
  logic                accept;
  logic                last_beat;
  logic                take;
`ifdef CMP_SECOND_BEST_EN
  logic [DATA_W-1:0]   second;
  logic [DATA_W-1:0]   second_nxt;
`endif

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (count == LAST_IDX);

  // Running-best update for the beat currently on in_dist. Beat 0 loads
  // unconditionally; later beats win only on a strict less-than so ties keep
  // the lower index.
  always_comb begin
    take          = (count == '0) || (in_dist < best_dist);
    best_dist_nxt = take ? in_dist : best_dist;
    best_arg_nxt  = take ? count : best_arg;
`ifdef CMP_SECOND_BEST_EN
    second_nxt = second;
    if (count == '0) begin
      second_nxt = '1;
    end else if (in_dist < best_dist) begin
      second_nxt = best_dist;
    end else if (in_dist < second) begin
      // Also covers a tie with the best: the tied value becomes second.
      second_nxt = in_dist;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last_beat) state_nxt = HOLD;
      HOLD:    if (out_ready)           state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Control and result registers; reset discards any partial frame or
  // pending result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      count      <= '0;
      frame_busy <= 1'b0;
      out_dist   <= '0;
      out_arg    <= '0;
`ifdef CMP_SECOND_BEST_EN
      out_dist2  <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        count      <= last_beat ? '0 : count + IDX_W'(1);
        frame_busy <= 1'b1;
        if (last_beat) begin
          out_dist  <= best_dist_nxt;
          out_arg   <= best_arg_nxt;
`ifdef CMP_SECOND_BEST_EN
          out_dist2 <= second_nxt;
`endif
        end
      end
      if (state == HOLD && out_ready) begin
        frame_busy <= 1'b0;
      end
    end
  end

  // Running-best datapath; beat 0 always overwrites, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      best_dist <= best_dist_nxt;
      best_arg  <= best_arg_nxt;
`ifdef CMP_SECOND_BEST_EN
      second    <= second_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_comparator_ncen_seq.sv
// Directed bench for comparator_ncen_seq: a default NUM_CEN=8 instance and a
// NUM_CEN=5 instance. Inputs change and outputs are sampled on the falling
// edge; the design acts on the rising edge.
module tb_comparator_ncen_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, frame_busy;
  logic [15:0] in_dist, out_dist;
  logic [2:0]  out_arg;
  logic        in_valid5, in_ready5, out_valid5, out_ready5, frame_busy5;
  logic [15:0] in_dist5, out_dist5;
  logic [2:0]  out_arg5;
`ifdef CMP_SECOND_BEST_EN
  logic [15:0] out_dist2, out_dist2_5;
`endif

  int tests = 0;
  int fails = 0;

  logic [15:0] fv  [8];
  logic [15:0] fv5 [5];

  comparator_ncen_seq #(.DATA_W(16), .NUM_CEN(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dist(out_dist), .out_arg(out_arg),
`ifdef CMP_SECOND_BEST_EN
    .out_dist2(out_dist2),
`endif
    .frame_busy(frame_busy)
  );

  comparator_ncen_seq #(.DATA_W(16), .NUM_CEN(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_dist(in_dist5),
    .out_valid(out_valid5), .out_ready(out_ready5),
    .out_dist(out_dist5), .out_arg(out_arg5),
`ifdef CMP_SECOND_BEST_EN
    .out_dist2(out_dist2_5),
`endif
    .frame_busy(frame_busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sends fv[0..7]; with gap set, in_valid drops for 3 cycles before beat 3.
  // Returns on the falling edge right after the final accept.
  task automatic send8(input bit gap);
    for (int i = 0; i < 8; i++) begin
      if (gap && i == 3) begin
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("gap_busy_hold", frame_busy, 1);
      end
      in_valid = 1'b1;
      in_dist  = fv[i];
      @(negedge clk);
      if (i == 0) check("busy_after_first", frame_busy, 1);
      if (i == 6) check("no_early_valid", out_valid, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic send5;
    for (int i = 0; i < 5; i++) begin
      in_valid5 = 1'b1;
      in_dist5  = fv5[i];
      @(negedge clk);
      if (i == 3) check("n5_no_early_valid", out_valid5, 0);
    end
    in_valid5 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_dist = '0; out_ready = 1'b0;
    in_valid5 = 1'b0; in_dist5 = '0; out_ready5 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_dist", out_dist, 0);
    check("rst_out_arg", out_arg, 0);
    check("rst_busy", frame_busy, 0);
`ifdef CMP_SECOND_BEST_EN
    check("rst_out_dist2", out_dist2, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, consumer always ready.
    out_ready = 1'b1;
    fv = '{16'd40, 16'd30, 16'd50, 16'd30, 16'd90, 16'd10, 16'd70, 16'd20};
    send8(1'b0);
    check("f1_valid", out_valid, 1);
    check("f1_in_ready", in_ready, 0);
    check("f1_dist", out_dist, 10);
    check("f1_arg", out_arg, 5);
`ifdef CMP_SECOND_BEST_EN
    check("f1_dist2", out_dist2, 20);
`endif
    @(negedge clk);
    check("f1_handoff_valid", out_valid, 0);
    check("f1_handoff_ready", in_ready, 1);
    check("f1_handoff_busy", frame_busy, 0);

    // Tie frame under back-pressure.
    out_ready = 1'b0;
    fv = '{16'd7, 16'd3, 16'd3, 16'd9, 16'd3, 16'd8, 16'd8, 16'd8};
    send8(1'b0);
    check("tie_valid", out_valid, 1);
    check("tie_dist", out_dist, 3);
    check("tie_arg", out_arg, 1);
`ifdef CMP_SECOND_BEST_EN
    check("tie_dist2", out_dist2, 3);
`endif
    in_valid = 1'b1;
    in_dist  = 16'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_dist", out_dist, 3);
      check("bp_arg", out_arg, 1);
      check("bp_busy", frame_busy, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_busy", frame_busy, 0);

    // Gapped all-ones frame; a consumed 0 during back-pressure would show here.
    fv = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    send8(1'b1);
    check("ones_valid", out_valid, 1);
    check("ones_dist", out_dist, 16'hFFFF);
    check("ones_arg", out_arg, 0);
`ifdef CMP_SECOND_BEST_EN
    check("ones_dist2", out_dist2, 16'hFFFF);
`endif
    @(negedge clk);

    // Reset after four beats of a frame.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_dist  = 16'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", frame_busy, 0);
    check("midrst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fv = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd6, 16'd7};
    send8(1'b0);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_dist", out_dist, 0);
    check("post_rst_arg", out_arg, 5);
`ifdef CMP_SECOND_BEST_EN
    check("post_rst_dist2", out_dist2, 1);
`endif
    @(negedge clk);
    check("post_rst_handoff", out_valid, 0);

    // Reset while a result is held.
    out_ready = 1'b0;
    fv = '{16'd40, 16'd30, 16'd50, 16'd30, 16'd90, 16'd10, 16'd70, 16'd20};
    send8(1'b0);
    check("hold_pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("hold_rst_valid", out_valid, 0);
    check("hold_rst_dist", out_dist, 0);
    check("hold_rst_arg", out_arg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_rst_no_stale", out_valid, 0);
    check("hold_rst_ready", in_ready, 1);

    // NUM_CEN=5 instance: wrap after five beats.
    out_ready5 = 1'b1;
    fv5 = '{16'd9, 16'd9, 16'd9, 16'd9, 16'd1};
    send5();
    check("n5_a_valid", out_valid5, 1);
    check("n5_a_dist", out_dist5, 1);
    check("n5_a_arg", out_arg5, 4);
`ifdef CMP_SECOND_BEST_EN
    check("n5_a_dist2", out_dist2_5, 9);
`endif
    @(negedge clk);
    check("n5_a_handoff", out_valid5, 0);
    fv5 = '{16'd2, 16'd5, 16'd7, 16'd3, 16'd4};
    send5();
    check("n5_b_valid", out_valid5, 1);
    check("n5_b_dist", out_dist5, 2);
    check("n5_b_arg", out_arg5, 0);
`ifdef CMP_SECOND_BEST_EN
    check("n5_b_dist2", out_dist2_5, 3);
`endif
    @(negedge clk);
    check("n5_b_handoff", out_valid5, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comparator_ncen_seq.md
Name: comparator_ncen_seq

Overview:
- Sequential, parametrised argmin unit for the centroid-distance path.
- Accepts NUM_CEN distances, one per cycle, over a valid/ready stream. Emits the minimum distance and its centroid index as one result beat.
- Replaces fixed-size combinational comparator trees when centroid count grows. It trades latency for area and a constant comparator count.

Parameters:
- DATA_W, 16, width of each unsigned distance.
- NUM_CEN, 8, distances per frame; legal range 2..1024.
- IDX_W, $clog2(NUM_CEN), width of the winner index.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  distance beat valid.
- in_ready  output  1  unit can accept a beat.
- in_dist  input  DATA_W  unsigned distance; index is implied by beat position in frame.
- out_valid  output  1  result held valid.
- out_ready  input  1  consumer accepts result.
- out_dist  output  DATA_W  minimum distance of frame.
- out_arg  output  IDX_W  index (0..NUM_CEN-1) of minimum.
- frame_busy  output  1  at least one beat of current frame accepted, result not yet emitted.

Behaviour:
- Reset (async assert, sync-release usage assumed by system):
  - state=ACCUM, count=0.
  - out_valid=0, out_dist=0, out_arg=0, frame_busy=0.
  - in_ready=1 one cycle after deassertion edge is not required; in_ready follows state combinationally.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept: in_valid && in_ready on a rising edge.
  - Beat k (count==k) is compared against the running best.
  - Beat 0 loads best_dist=in_dist, best_arg=0 unconditionally.
  - Beat k>0 replaces the best only if in_dist < best_dist (strict). Ties keep the lower index.
  - count increments; frame_busy=1 after the first accept.
- Final beat: accept with count==NUM_CEN-1.
  - That beat's comparison is included.
  - out_dist/out_arg are registered, state goes to HOLD, count wraps to 0.
  - out_valid rises the cycle after the final accept; latency is one clock from last beat to result.
- HOLD:
  - out_dist/out_arg are stable while out_valid && !out_ready.
  - in_valid is ignored; no beats are accepted.
- Handoff: out_valid && out_ready → ACCUM next cycle, frame_busy=0. in_ready=1 in that next cycle; there is no bypass from out_ready to in_ready.
  - Throughput: NUM_CEN+1 cycles per frame minimum.
- Gaps: in_valid may drop mid-frame. count and best hold indefinitely.
- Values: distances are unsigned. 0 and all-ones are legal; all-ones on every beat yields out_arg=0.
- Reset mid-frame or in HOLD: discards the partial frame and any pending result immediately. out_valid falls asynchronously.
- Width rule: no arithmetic beyond the compare and the counter. Counter width IDX_W is sufficient; non-power-of-2 NUM_CEN wraps at NUM_CEN-1, not at 2^IDX_W-1.

Optional Feature:
- Macro CMP_SECOND_BEST_EN.
- Defined:
  - Adds output out_dist2 (DATA_W), the second-smallest distance of the frame, for winner-confidence margin.
  - Beat 0 sets second=all-ones.
  - On a new strict best, second takes the old best.
  - Otherwise, if in_dist < second, second takes in_dist.
  - A tie with the best updates second to that value.
  - Registered and held with out_dist; resets to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then frame 40,30,50,30,90,10,70,20 contiguous, out_ready=1 → out_valid one cycle after 8th accept, out_dist=10, out_arg=5; with macro out_dist2=20.
- Tie frame 7,3,3,9,3,8,8,8 → out_dist=3, out_arg=1 (lowest tied index); with macro out_dist2=3.
- Back-pressure: hold out_ready=0 for 5 cycles after result, drive in_valid=1 → in_ready=0, outputs stable, no beat consumed; release → next frame starts count=0.
- Gapped frame with in_valid low 3 cycles between beats 2 and 3, values 0xFFFF×8 → out_dist=0xFFFF, out_arg=0.
- Assert rst_n=0 after beat 4 of a frame, release, send frame 5,4,3,2,1,0,6,7 → out_arg=5, out_dist=0; no stale result appears.
- NUM_CEN=5 build, frame 9,9,9,9,1 → out_arg=4, count wraps after 5 beats; second frame 2,… → out_arg correct, min 2.
